// File: rtl/data_mem_hs.sv
// RV32 byte-addressable data memory with valid/ready handshakes; response WAIT_STATES+1 edges after accept, held under rsp_ready back-pressure.
// Define DATA_MEM_MISALIGN_EN to perform misaligned H/W accesses byte-wise instead of faulting them.
module data_mem_hs #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          DEPTH = 2 ** ADDR_W;
  localparam logic [32:0] LIMIT = 33'd1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } req_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept;

  logic [7:0]  mem_q [DEPTH] = '{default: 8'h00};

  logic [2:0]        size_m1;
  logic              op_bad;
  logic              range_bad;
  logic              misalign;
  logic              req_err;
  logic [32:0]       last_byte;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] rd_base;
  logic [7:0]        rb0, rb1, rb2, rb3;
  logic [31:0]       ld_data;

  // Request decode: fault is decided entirely from the accepted request.
  always_comb begin
    size_m1 = 3'd0;
    op_bad  = 1'b0;
    case (req_op)
      3'b000, 3'b100: size_m1 = 3'd0;
      3'b001, 3'b101: size_m1 = 3'd1;
      3'b010:         size_m1 = 3'd3;
      default:        op_bad  = 1'b1;
    endcase
    if (req_we && req_op[2]) op_bad = 1'b1;
    last_byte = {1'b0, req_addr} + {30'd0, size_m1};
    range_bad = (last_byte >= LIMIT);
`ifdef DATA_MEM_MISALIGN_EN
    misalign  = 1'b0;
`else
    misalign  = ((size_m1 == 3'd1) && req_addr[0]) ||
                ((size_m1 == 3'd3) && (req_addr[1:0] != 2'b00));
`endif
    req_err   = op_bad || range_bad || misalign;
  end

  assign wr_base = req_addr[ADDR_W-1:0];

  // Stores commit at the accept edge, only on the lanes the op touches.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      mem_q[wr_base] <= req_wdata[7:0];
      if (size_m1 != 3'd0) mem_q[wr_base + ADDR_W'(1)] <= req_wdata[15:8];
      if (size_m1 == 3'd3) begin
        mem_q[wr_base + ADDR_W'(2)] <= req_wdata[23:16];
        mem_q[wr_base + ADDR_W'(3)] <= req_wdata[31:24];
      end
    end
  end

  always_comb begin
    rd_base = req_q.addr;
    rb0     = mem_q[rd_base];
    rb1     = mem_q[rd_base + ADDR_W'(1)];
    rb2     = mem_q[rd_base + ADDR_W'(2)];
    rb3     = mem_q[rd_base + ADDR_W'(3)];
    case (req_q.op)
      3'b000:  ld_data = {{24{rb0[7]}}, rb0};
      3'b100:  ld_data = {24'd0, rb0};
      3'b001:  ld_data = {{16{rb1[7]}}, rb1, rb0};
      3'b101:  ld_data = {16'd0, rb1, rb0};
      default: ld_data = {rb3, rb2, rb1, rb0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_WAIT;
          cnt_d      = 3'(WAIT_STATES);
          req_d.we   = req_we;
          req_d.op   = req_op;
          req_d.addr = req_addr[ADDR_W-1:0];
          req_d.err  = req_err;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RESP;
          err_d   = req_q.err;
          rdata_d = (req_q.err || req_q.we) ? 32'd0 : ld_data;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst_n && (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    accept    = req_ready && req_valid;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: two instances (1 and 3 wait states) driven in lockstep, checked against a byte-array model
// every cycle plus literal expectations per transaction; honours DATA_MEM_MISALIGN_EN.
module tb_data_mem_hs;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WS1    = 1;
  localparam int WS3    = 3;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [2:0]  req_op    = 3'b000;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;

  logic        rdy1, vld1, err1, rdy3, vld3, err3;
  logic [31:0] rdata1, rdata3;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ref_mem [DEPTH];
  bit          pend      = 1'b0;
  int          age       = 0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err   = 1'b0;

  always #5 clk = ~clk;

  data_mem_hs #(.ADDR_W(ADDR_W), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld1),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata1), .rsp_err(err1)
  );

  data_mem_hs #(.ADDR_W(ADDR_W), .WAIT_STATES(WS3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld3),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata3), .rsp_err(err3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference: access size from op, fault rules, little-endian bytes, extension.
  function automatic void model_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int          sz;
    int          a;
    logic [31:0] v;
    rd = 32'd0;
    er = 1'b0;
    case (op)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    if (sz == 0) er = 1'b1;
    if (we && (op == 3'b100 || op == 3'b101)) er = 1'b1;
    if (sz != 0 && (longint'({32'h0, addr}) + longint'(sz) - 1) >= longint'(DEPTH)) er = 1'b1;
`ifndef DATA_MEM_MISALIGN_EN
    if (sz != 0 && (addr % 32'(sz)) != 32'd0) er = 1'b1;
`endif
    if (!er) begin
      a = int'(addr);
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[a + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[a + i];
        if (!op[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!op[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endfunction

  task automatic chk_dut(input string tag, input int ws, input logic rdy, input logic vld,
                         input logic [31:0] rd, input logic er);
    logic ev;
    ev = pend && (age >= ws + 1);
    chkb({tag, " req_ready"}, rdy, !pend);
    chkb({tag, " rsp_valid"}, vld, ev);
    if (ev) begin
      chk({tag, " rsp_rdata"}, rd, exp_rdata);
      chkb({tag, " rsp_err"}, er, exp_err);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      chkb("reset d1 req_ready", rdy1, 1'b0);
      chkb("reset d3 req_ready", rdy3, 1'b0);
      chkb("reset d1 rsp_valid", vld1, 1'b0);
      chkb("reset d3 rsp_valid", vld3, 1'b0);
      chk("reset d1 rsp_rdata", rdata1, 32'd0);
      chk("reset d3 rsp_rdata", rdata3, 32'd0);
      chkb("reset d1 rsp_err", err1, 1'b0);
      chkb("reset d3 rsp_err", err3, 1'b0);
    end else begin
      chk_dut("cyc d1", WS1, rdy1, vld1, rdata1, err1);
      chk_dut("cyc d3", WS3, rdy3, vld3, rdata3, err3);
    end
  end

  // One transaction; response released once both instances should be valid, plus 'hold' extra stalled cycles.
  task automatic xfer(input string nm, input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold, input bit noise,
                      input logic [31:0] lit_rd, input logic lit_er);
    int          lat1, lat3;
    logic [31:0] mr;
    logic        me;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    model_access(we, op, addr, wdata, mr, me);
    exp_rdata = mr; exp_err = me; pend = 1'b1; age = 0;
    lat1 = -1; lat3 = -1;
    @(negedge clk);
    req_valid = noise;
    if (noise) begin
      req_we = 1'b1; req_op = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    end
    for (int c = 0; c <= WS3 + 1 + hold; c++) begin
      if (c > 0) begin
        @(posedge clk); age++;
        @(negedge clk);
      end
      if (lat1 < 0 && vld1) lat1 = age;
      if (lat3 < 0 && vld3) lat3 = age;
    end
    chk({nm, " d1 rdata"}, rdata1, lit_rd);
    chkb({nm, " d1 err"}, err1, lit_er);
    chk({nm, " d3 rdata"}, rdata3, lit_rd);
    chkb({nm, " d3 err"}, err3, lit_er);
    chk({nm, " d1 latency"}, 32'(lat1), 32'd2);
    chk({nm, " d3 latency"}, 32'(lat3), 32'd4);
    rsp_ready = 1'b1;
    @(posedge clk);
    pend = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] mr;
    logic        me;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    xfer("sw_10",   1'b1, 3'b010, 32'h10, 32'h800000FF, 0, 1'b0, 32'h00000000, 1'b0);
    xfer("lw_10",   1'b0, 3'b010, 32'h10, 32'h0,        0, 1'b0, 32'h800000FF, 1'b0);
    xfer("sb_11",   1'b1, 3'b000, 32'h11, 32'h123456AB, 0, 1'b0, 32'h00000000, 1'b0);
    xfer("lw_10b",  1'b0, 3'b010, 32'h10, 32'h0,        0, 1'b0, 32'h8000ABFF, 1'b0);
    xfer("lb_11",   1'b0, 3'b000, 32'h11, 32'h0,        0, 1'b0, 32'hFFFFFFAB, 1'b0);
    xfer("lbu_11",  1'b0, 3'b100, 32'h11, 32'h0,        0, 1'b0, 32'h000000AB, 1'b0);
    xfer("lh_12",   1'b0, 3'b001, 32'h12, 32'h0,        0, 1'b0, 32'hFFFF8000, 1'b0);
    xfer("lhu_12",  1'b0, 3'b101, 32'h12, 32'h0,        0, 1'b0, 32'h00008000, 1'b0);
    xfer("sh_12",   1'b1, 3'b001, 32'h12, 32'h0000BEEF, 0, 1'b0, 32'h00000000, 1'b0);
    xfer("lw_10c",  1'b0, 3'b010, 32'h10, 32'h0,        0, 1'b0, 32'hBEEFABFF, 1'b0);
`ifdef DATA_MEM_MISALIGN_EN
    xfer("lw_11",   1'b0, 3'b010, 32'h11, 32'h0,        0, 1'b0, 32'h00BEEFAB, 1'b0);
`else
    xfer("lw_11",   1'b0, 3'b010, 32'h11, 32'h0,        0, 1'b0, 32'h00000000, 1'b1);
`endif
    xfer("sw_3fe",  1'b1, 3'b010, 32'h3FE, 32'h11223344, 0, 1'b0, 32'h00000000, 1'b1);
    xfer("lhu_3fe", 1'b0, 3'b101, 32'h3FE, 32'h0,        0, 1'b0, 32'h00000000, 1'b0);
    xfer("st_op4",  1'b1, 3'b100, 32'h10, 32'h00000055, 0, 1'b0, 32'h00000000, 1'b1);
    xfer("lbu_10",  1'b0, 3'b100, 32'h10, 32'h0,        0, 1'b0, 32'h000000FF, 1'b0);
    xfer("op_011",  1'b0, 3'b011, 32'h10, 32'h0,        0, 1'b0, 32'h00000000, 1'b1);
    xfer("lw_400",  1'b0, 3'b010, 32'h400, 32'h0,       0, 1'b0, 32'h00000000, 1'b1);
    xfer("lb_top",  1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,  0, 1'b0, 32'h00000000, 1'b1);
    xfer("sb_3ff",  1'b1, 3'b000, 32'h3FF, 32'h0000005A, 0, 1'b0, 32'h00000000, 1'b0);
    xfer("lbu_3ff", 1'b0, 3'b100, 32'h3FF, 32'h0,        0, 1'b0, 32'h0000005A, 1'b0);
    xfer("lh_3ff",  1'b0, 3'b001, 32'h3FF, 32'h0,        0, 1'b0, 32'h00000000, 1'b1);

    // Stalled response with a store request waved at the busy block.
    xfer("lw_bp",   1'b0, 3'b010, 32'h10, 32'h0,        4, 1'b1, 32'hBEEFABFF, 1'b0);
    xfer("lw_10d",  1'b0, 3'b010, 32'h10, 32'h0,        0, 1'b0, 32'hBEEFABFF, 1'b0);

    // Reset while the store is outstanding.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    model_access(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, mr, me);
    exp_rdata = mr; exp_err = me; pend = 1'b1; age = 0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); age++;
    end
    @(negedge clk);
    chkb("pre_rst d1 rsp_valid", vld1, 1'b1);
    chkb("pre_rst d3 rsp_valid", vld3, 1'b0);
    rst_n = 1'b0;
    pend  = 1'b0;
    #1;
    chkb("rst d1 rsp_valid drop", vld1, 1'b0);
    chkb("rst d3 req_ready", rdy3, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chkb("rel d1 req_ready", rdy1, 1'b1);
    chkb("rel d3 req_ready", rdy3, 1'b1);
    xfer("lw_20",   1'b0, 3'b010, 32'h20, 32'h0,        0, 1'b0, 32'hCAFEF00D, 1'b0);

`ifdef DATA_MEM_MISALIGN_EN
    xfer("sw_0e",   1'b1, 3'b010, 32'h0E, 32'hA1B2C3D4, 0, 1'b0, 32'h00000000, 1'b0);
    xfer("lw_0c",   1'b0, 3'b010, 32'h0C, 32'h0,        0, 1'b0, 32'hC3D40000, 1'b0);
`else
    xfer("sw_0e",   1'b1, 3'b010, 32'h0E, 32'hA1B2C3D4, 0, 1'b0, 32'h00000000, 1'b1);
    xfer("lw_0c",   1'b0, 3'b010, 32'h0C, 32'h0,        0, 1'b0, 32'h00000000, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
# data_mem_hs

Parametrised byte-addressable RV32 data memory with a valid/ready request/response handshake, configurable wait states and per-byte write lanes. It sits between the MEM stage (or a future load/store unit) and the data RAM, replacing the fixed single-cycle data memory. It adds:
- correct partial stores that leave untouched bytes intact;
- alignment and range checking with an error response;
- response back-pressure.

## Interface
Parameters:
- ADDR_W, 10: byte-address bits; memory holds 2**ADDR_W bytes.
- WAIT_STATES, 1: extra cycles between accept and response, 0..7.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 store, 0 load
- req_op  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address, little-endian
- req_wdata  in  32  store data; low bytes used for B/H
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access faulted

## Operation
- Storage is a byte array of 2**ADDR_W entries.
  - Contents are zero at time 0.
  - Contents are not cleared by rst_n.
- The FSM has three states: IDLE, WAIT and RESP. Only one request is outstanding at a time.
  - IDLE: req_ready=1. When req_valid is high, the request is accepted: latch we/op/addr, load the counter with WAIT_STATES, go to WAIT.
  - WAIT: when the counter is 0, go to RESP on the next edge and register the response; otherwise decrement the counter.
  - RESP: rsp_valid=1. When rsp_ready is high, go to IDLE.
- Stores commit at the accept edge, byte-lane masked:
  - B writes addr;
  - H writes addr..addr+1;
  - W writes addr..addr+3.
  - Other bytes are preserved.
- Loads read at the WAIT→RESP edge. B/H sign-extend; BU/HU zero-extend.
- Error conditions. Any one of these faults the request: rsp_err=1, rsp_rdata=0, no RAM write.
  - req_op not in {000,001,010,100,101}.
  - Store with op 100 or 101.
  - Any accessed byte address ≥ 2**ADDR_W (full 32-bit compare).
  - Misaligned access: H with addr[0]≠0, or W with addr[1:0]≠0. This check depends on the macro (see Configuration).
- The error is computed at accept and carried to the response.

## Timing
- Reset values: req_ready=0 while rst_n=0; state IDLE; rsp_valid=0; rsp_rdata=0; rsp_err=0; counter=0.
- req_ready is 1 in the first cycle after rst_n deasserts.
- Latency: accept at edge k gives rsp_valid=1 after edge k+1+WAIT_STATES.
- rsp_rdata and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
- The response handshake at edge m returns the block to IDLE. req_ready=1 after edge m, so the next accept is no earlier than edge m+1.
- Best-case throughput is one access per WAIT_STATES+3 cycles.
- req_* inputs are ignored outside IDLE.
- A load following a store sees the stored data, because the store committed earlier.
- Reset asserted mid-operation:
  - the block returns to IDLE immediately and drops the pending response;
  - a store already committed at accept remains in memory.

## Configuration
- DATA_MEM_MISALIGN_EN defined:
  - misaligned H/W accesses are performed byte-wise from addr upward;
  - this may cross a word boundary;
  - the access faults only if a byte is out of range or the op is invalid.
- DATA_MEM_MISALIGN_EN undefined: misaligned H/W accesses fault with rsp_err=1.

## Test plan
1. SW 0x800000FF @0x10, then LW @0x10 → rsp_rdata 0x800000FF, rsp_err 0. With WAIT_STATES=1, rsp_valid rises 2 edges after accept.
2. SB 0x123456AB @0x11, then LW @0x10 → 0x8000ABFF.
   - LB @0x11 → 0xFFFFFFAB.
   - LBU @0x11 → 0x000000AB.
3. Half-word loads after test 2:
   - LH @0x12 → 0xFFFF8000.
   - LHU @0x12 → 0x00008000.
   - SH 0x0000BEEF @0x12, then LW @0x10 → 0xBEEFABFF.
4. Fault cases, with macro undefined:
   - LW @0x11 → rsp_err 1, rsp_rdata 0.
   - SW @0x3FE (ADDR_W=10) → rsp_err 1 and RAM unchanged.
   - Store with op 100 → rsp_err 1.
   - With macro defined: SW 0xA1B2C3D4 @0x0E, then LW @0x0C → bytes 0x0E/0x0F hold D4/C3, rsp_err 0.
5. Back-pressure and latency, WAIT_STATES=3:
   - rsp_ready held low 4 cycles → rsp_valid, rsp_rdata and rsp_err stable, and req_ready=0 throughout.
   - Latency from accept to rsp_valid is 4 edges.
6. Reset mid-operation: assert rst_n=0 during WAIT of an SW 0xCAFEF00D @0x20.
   - rsp_valid drops at once; req_ready=1 after release.
   - A subsequent LW @0x20 returns 0xCAFEF00D.
